// File: rtl/clk_step_controller.sv
// Processor clock-enable controller: free-run with a programmable period, debounced
// single-step, and a halt/trap state driven by the processor's halt request.
module clk_step_controller #(
    parameter int DEB_CYCLES = 4,
    parameter int CNT_W      = 16
) (
    input  logic             In_clk,
    input  logic             reset,
    input  logic             run,
    input  logic             step_btn,
    input  logic [2:0]       div_sel,
    input  logic             halt_in,
    output logic             cpu_en,
    output logic [1:0]       state,
    output logic [CNT_W-1:0] cycle_count
);

    typedef enum logic [1:0] {
        ST_HALT = 2'b00,
        ST_RUN  = 2'b01,
        ST_STEP = 2'b10,
        ST_TRAP = 2'b11
    } state_t;

    localparam int DEB_W = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES + 1) : 1;
    localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEB_CYCLES - 1);

    state_t           state_reg, state_next;
    logic [DEB_W-1:0] db_cnt_reg;
    logic             db_level_reg;
    logic             db_prev_reg;
    logic             step_armed_reg;
    logic             step_rise;
    logic [7:0]       presc_reg;
    logic [2:0]       div_q_reg;
    logic [8:0]       t_wide;
    logic [7:0]       t_val;
    logic             presc_at_t;
    logic             cpu_en_reg, cpu_en_next;
    logic [CNT_W-1:0] count_reg;

    // Debounce: the accepted level moves only after DEB_CYCLES straight samples that differ.
    always_ff @(posedge In_clk) begin
        if (reset) begin
            db_cnt_reg     <= '0;
            db_level_reg   <= 1'b0;
            db_prev_reg    <= 1'b0;
            step_armed_reg <= 1'b0;
        end else begin
            db_prev_reg <= db_level_reg;
            if (step_btn != db_level_reg) begin
                if (db_cnt_reg == DEB_LAST) begin
                    db_level_reg <= step_btn;
                    db_cnt_reg   <= '0;
                end else begin
                    db_cnt_reg <= db_cnt_reg + 1'b1;
                end
            end else begin
                db_cnt_reg <= '0;
            end
            // A button held through reset must be seen released before a press counts.
            if (!db_level_reg && !step_btn && (db_cnt_reg == '0))
                step_armed_reg <= 1'b1;
        end
    end

    assign step_rise  = db_level_reg & ~db_prev_reg & step_armed_reg;
    assign t_wide     = (9'd2 << div_q_reg) - 9'd1;
    assign t_val      = t_wide[7:0];
    assign presc_at_t = (presc_reg == t_val);

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_HALT: begin
                if (run && !halt_in)
                    state_next = ST_RUN;
                else if (!run && step_rise)
                    state_next = ST_STEP;
            end
            ST_RUN: begin
                if (!run)
                    state_next = ST_HALT;
                else if (halt_in)
                    state_next = ST_TRAP;
            end
            ST_STEP: state_next = ST_HALT;
            ST_TRAP: begin
                if (!run)
                    state_next = ST_HALT;
            end
            default: state_next = ST_HALT;
        endcase
    end

    // A period ending on the same cycle RUN is left produces no pulse.
    always_comb begin
        cpu_en_next = 1'b0;
        if (state_reg == ST_RUN && presc_at_t && state_next == ST_RUN)
            cpu_en_next = 1'b1;
        else if (state_reg == ST_STEP)
            cpu_en_next = 1'b1;
    end

    always_ff @(posedge In_clk) begin
        if (reset) begin
            state_reg  <= ST_HALT;
            cpu_en_reg <= 1'b0;
            count_reg  <= '0;
            presc_reg  <= '0;
            div_q_reg  <= div_sel;
        end else begin
            state_reg  <= state_next;
            cpu_en_reg <= cpu_en_next;
            if (cpu_en_next && (count_reg != {CNT_W{1'b1}}))
                count_reg <= count_reg + 1'b1;
            if (state_reg == ST_RUN && state_next == ST_RUN) begin
                if (presc_at_t) begin
                    presc_reg <= '0;
                    div_q_reg <= div_sel;
                end else begin
                    presc_reg <= presc_reg + 8'd1;
                end
            end else begin
                presc_reg <= '0;
                if (state_reg == ST_HALT && state_next == ST_RUN)
                    div_q_reg <= div_sel;
            end
        end
    end

    assign cpu_en      = cpu_en_reg;
    assign state       = state_reg;
    assign cycle_count = count_reg;

endmodule

// File: doc/clk_step_controller.md
CLK_STEP_CONTROLLER -- requirements
Module: clk_step_controller

Interface
REQ-001 SHALL have parameter DEB_CYCLES, default 4, the number of consecutive cycles step_btn must be stable before its level is accepted.
REQ-002 SHALL have parameter CNT_W, default 16, the width of cycle_count.
REQ-003 SHALL have port In_clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-005 SHALL have port run, input, 1 bit: level; 1 selects free-running, 0 selects halt/single-step.
REQ-006 SHALL have port step_btn, input, 1 bit: raw, bouncy single-step pushbutton; active high.
REQ-007 SHALL have port div_sel, input, 3 bits: run-mode enable period select; period = 2^(div_sel+1) In_clk cycles (2..256).
REQ-008 SHALL have port halt_in, input, 1 bit: processor halt request (e.g. syscall/break); level-sampled.
REQ-009 SHALL have port cpu_en, output, 1 bit: registered one-cycle clock-enable pulse to the processor datapath.
REQ-010 SHALL have port state, output, 2 bits: HALT=00, RUN=01, STEP=10, TRAP=11.
REQ-011 SHALL have port cycle_count, output, CNT_W bits: number of cpu_en pulses issued since reset.

Function
REQ-012 SHALL implement a 4-state FSM: HALT, RUN, STEP, TRAP.
REQ-013 SHALL transition HALT->RUN when run=1 and halt_in=0; RUN->HALT when run=0; RUN->TRAP when halt_in=1; TRAP->HALT only when run=0; STEP->HALT unconditionally after one cycle.
REQ-014 SHALL transition HALT->STEP on a rising edge of the debounced step signal while run=0; step edges in RUN or TRAP are discarded, not queued.
REQ-015 SHALL debounce step_btn with a counter: the debounced level changes only after step_btn differs from it for DEB_CYCLES consecutive cycles; any reversal restarts the count.
REQ-016 SHALL hold an 8-bit prescaler at 0 in every state except RUN; in RUN it increments each cycle and wraps to 0 at terminal T = 2^(div_q+1)-1.
REQ-017 SHALL latch div_sel into div_q at reset, on HALT->RUN entry and at each prescaler wrap only; div_sel changes mid-period do not alter the current period.
REQ-018 SHALL assert cpu_en for exactly one cycle, registered, in the cycle after the prescaler equals T in RUN (first pulse T+1 cycles after RUN entry, then every T+1 cycles).
REQ-019 SHALL assert cpu_en for exactly one cycle in the cycle after entering STEP; one accepted step edge yields exactly one pulse.
REQ-020 SHALL NOT assert cpu_en in HALT or TRAP, nor in the cycle after a RUN->TRAP or RUN->HALT transition, even if the prescaler hits T in the same cycle (halt_in/run=0 wins).
REQ-021 SHALL increment cycle_count by 1 in the same cycle cpu_en is high and saturate at all-ones (no wrap).
REQ-022 SHALL keep cycle_count unchanged across HALT/RUN/STEP/TRAP transitions; only reset clears it.
REQ-023 SHALL drive state directly from the FSM register.

Reset
REQ-024 SHALL, when reset=1 at a rising edge, set state=HALT, cpu_en=0, cycle_count=0, prescaler=0, debounce counter=0, debounced step level=0, div_q=div_sel.
REQ-025 SHALL give reset priority over all other inputs, including mid-period in RUN and during STEP; no cpu_en pulse follows the reset edge.
REQ-026 SHALL treat step_btn held high through reset release as already-high after debounce, producing no step until released and re-pressed.

Verification
REQ-027 Run, div_sel=1: run=1 from HALT -> cpu_en pulses every 4 cycles, first pulse 4 cycles after RUN entry; 10 pulses -> cycle_count=10.
REQ-028 Step debounce: run=0, step_btn toggles every cycle for 10 cycles then held high 6 cycles -> exactly one cpu_en pulse, state sequence HALT->STEP->HALT, cycle_count+1.
REQ-029 Trap: RUN, div_sel=0, halt_in=1 on cycle the prescaler reaches T -> no pulse, state=11; run stays 1 -> remains TRAP; run=0 -> HALT; run=1 with halt_in=0 -> RUN.
REQ-030 div_sel change: RUN with div_sel=2, change to 0 mid-period -> current period stays 8 cycles, following periods 2 cycles.
REQ-031 Saturation: CNT_W=4, run with div_sel=0 for 40 cycles -> cycle_count stops at 15, cpu_en continues pulsing.
REQ-032 Reset mid-run: reset=1 for 1 cycle in RUN at prescaler=T -> next cycle cpu_en=0, state=00, cycle_count=0.
